// File: rtl/simon_core_arbiter.sv
// simon_core_arbiter
//   Time-shares one simon_top encrypt/decrypt core between NREQ requesters
//   (requester 0 = RAS spill/fill engine, requester 1 = MMIO crypto client).
//   Round-robin arbitration; the owner keeps its grant from issue until it
//   consumes its result. Operands are not latched here: the core captures
//   them on valid_i & ready_o while the requester holds them stable.
// Ports
//   clk, arst_n                     clock, asynchronous active-low reset
//   req_valid/ready/mode/pt/key     request side, requester n at slice n
//   rsp_valid/rsp_ready, rsp_ct     response handshake per requester, shared result bus
//   core_valid_i/mode_i/pt_i/key_i  to simon_top
//   core_ready_o/valid_o/ct_o       from simon_top
//   core_ready_i                    to simon_top (result consumed)
//   grant, busy                     one-hot owner, FSM not idle
//   err_timeout, err_clr            sticky slow-core flag and its synchronous clear
module simon_core_arbiter #(
    parameter int W       = 32,
    parameter int NKW     = 4,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_mode,
    input  logic [NREQ*2*W-1:0]   req_pt,
    input  logic [NREQ*NKW*W-1:0] req_key,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [2*W-1:0]        rsp_ct,
    output logic                  core_valid_i,
    output logic                  core_mode_i,
    output logic [2*W-1:0]        core_pt_i,
    output logic [NKW*W-1:0]      core_key_i,
    input  logic                  core_ready_o,
    input  logic                  core_valid_o,
    output logic                  core_ready_i,
    input  logic [2*W-1:0]        core_ct_o,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  err_timeout,
    input  logic                  err_clr
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   busy_cnt_q, busy_cnt_d;
    logic            err_q, err_d;

    // rr_ptr doubles as the owner index while a grant is held
    logic             sel_valid, sel_mode, sel_rsp_ready;
    logic [2*W-1:0]   sel_pt;
    logic [NKW*W-1:0] sel_key;
    logic             found;
    logic [PW-1:0]    win;
    logic [NREQ-1:0]  win_oh;

    always_comb begin
        sel_valid     = 1'b0;
        sel_mode      = 1'b0;
        sel_rsp_ready = 1'b0;
        sel_pt        = '0;
        sel_key       = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (rr_ptr_q == PW'(n)) begin
                sel_valid     = req_valid[n];
                sel_mode      = req_mode[n];
                sel_rsp_ready = rsp_ready[n];
                sel_pt        = req_pt[n*2*W +: 2*W];
                sel_key       = req_key[n*NKW*W +: NKW*W];
            end
        end
    end

    // Circular search starting one past the last winner; outer loop order
    // gives priority, so the first hit in rotation wins.
    always_comb begin
        found  = 1'b0;
        win    = rr_ptr_q;
        win_oh = '0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int n = 0; n < NREQ; n++) begin
                if (!found && req_valid[n] && (((int'(rr_ptr_q) + i) % NREQ) == n)) begin
                    found = 1'b1;
                    win   = PW'(n);
                end
            end
        end
        win_oh[win] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        busy_cnt_d   = busy_cnt_q;
        err_d        = err_clr ? 1'b0 : err_q;
        req_ready    = '0;
        rsp_valid    = '0;
        rsp_ct       = '0;
        core_valid_i = 1'b0;
        core_mode_i  = 1'b0;
        core_pt_i    = '0;
        core_key_i   = '0;
        core_ready_i = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d  = win_oh;
                    rr_ptr_d = win;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_valid_i = sel_valid;
                core_mode_i  = sel_mode;
                core_pt_i    = sel_pt;
                core_key_i   = sel_key;
                if (!sel_valid) begin
                    // withdrawn before the core took it; pointer keeps the winner
                    grant_d = '0;
                    state_d = S_IDLE;
                end else if (core_ready_o) begin
                    req_ready  = grant_q;
                    busy_cnt_d = '0;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                // counter runs one past the trip point so a cleared flag stays clear
                if (busy_cnt_q != CNT_MAX) busy_cnt_d = busy_cnt_q + 1'b1;
                if (busy_cnt_q == CNT_LAST) err_d = 1'b1;
                if (core_valid_o) state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid    = grant_q & {NREQ{core_valid_o}};
                rsp_ct       = core_ct_o;
                core_ready_i = sel_rsp_ready & core_valid_o;
                if (core_ready_i) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= PW'(NREQ - 1);
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_cnt_q <= busy_cnt_d;
            err_q      <= err_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_simon_core_arbiter.sv
// Bench for simon_core_arbiter: a behavioural Simon64/128 core stand-in with
// adjustable latency, a round-robin reference and scenario tasks.
module tb_simon_core_arbiter;
    localparam int W = 32, NKW = 4, NREQ = 2, TIMEOUT = 8;

    logic                  clk = 1'b0, arst_n = 1'b1;
    logic [NREQ-1:0]       req_valid, req_ready, req_mode, rsp_valid, rsp_ready, grant;
    logic [NREQ*2*W-1:0]   req_pt;
    logic [NREQ*NKW*W-1:0] req_key;
    logic [2*W-1:0]        rsp_ct, core_pt_i, core_ct_o;
    logic [NKW*W-1:0]      core_key_i;
    logic core_valid_i, core_mode_i, core_ready_o, core_valid_o, core_ready_i;
    logic busy, err_timeout, err_clr;

    logic core_rdy_en, core_hold;
    int   core_lat;
    logic c_busy, c_vo;
    int   c_cnt;
    logic [63:0] c_res;

    int n_cmp = 0, n_bad = 0;
    int rr_last;

    simon_core_arbiter #(.W(W), .NKW(NKW), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_pt(req_pt), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ct(rsp_ct),
        .core_valid_i(core_valid_i), .core_mode_i(core_mode_i), .core_pt_i(core_pt_i),
        .core_key_i(core_key_i), .core_ready_o(core_ready_o), .core_valid_o(core_valid_o),
        .core_ready_i(core_ready_i), .core_ct_o(core_ct_o),
        .grant(grant), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sf(input logic [31:0] x);
        return ({x[30:0], x[31]} & {x[23:0], x[31:24]}) ^ {x[29:0], x[31:30]};
    endfunction

    // Simon64/128, 44 rounds
    function automatic logic [63:0] simon(input logic dec, input logic [63:0] blk, input logic [127:0] key);
        logic [31:0] k [0:43];
        logic [31:0] x, y, t;
        logic [61:0] z;
        z = 62'b11011011101011000110010111100000010010001010011100110100001111;
        for (int i = 0; i < 4; i++) k[i] = key[i*32 +: 32];
        for (int i = 4; i < 44; i++) begin
            t = {k[i-1][2:0], k[i-1][31:3]} ^ k[i-3];
            t = t ^ {t[0], t[31:1]};
            k[i] = ~k[i-4] ^ t ^ 32'((z >> (61 - (i - 4))) & 62'd1) ^ 32'd3;
        end
        x = blk[63:32];
        y = blk[31:0];
        if (!dec) begin
            for (int i = 0; i < 44; i++) begin t = x; x = y ^ sf(x) ^ k[i]; y = t; end
        end else begin
            for (int i = 43; i >= 0; i--) begin t = y; y = x ^ sf(y) ^ k[i]; x = t; end
        end
        return {x, y};
    endfunction

    // core stand-in
    assign core_ready_o = core_rdy_en && !c_busy && !c_vo;
    assign core_valid_o = c_vo;
    assign core_ct_o    = c_vo ? c_res : '0;
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            c_busy <= 1'b0; c_vo <= 1'b0; c_cnt <= 0; c_res <= '0;
        end else if (c_vo) begin
            if (core_ready_i) c_vo <= 1'b0;
        end else if (c_busy) begin
            if (c_cnt > 0) c_cnt <= c_cnt - 1;
            else if (!core_hold) begin c_busy <= 1'b0; c_vo <= 1'b1; end
        end else if (core_valid_i && core_ready_o) begin
            c_busy <= 1'b1; c_cnt <= core_lat;
            c_res  <= simon(core_mode_i, core_pt_i, core_key_i);
        end
    end

    function automatic logic [NREQ-1:0] onehot(input int n);
        logic [NREQ-1:0] v;
        v = '0; v[n] = 1'b1;
        return v;
    endfunction

    // reference round-robin: first pending requester after the last winner
    function automatic int ref_winner(input logic [NREQ-1:0] pend, input int last);
        for (int i = 1; i <= NREQ; i++) if (pend[(last + i) % NREQ]) return (last + i) % NREQ;
        return -1;
    endfunction

    function automatic bit outs_zero();
        return ({grant, busy, err_timeout, req_ready, rsp_valid, core_valid_i, core_mode_i,
                 core_ready_i, core_pt_i, core_key_i, rsp_ct} === '0);
    endfunction

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic set_req(input int r, input logic m, input logic [63:0] pt, input logic [127:0] key);
        req_mode[r] = m; req_pt[r*64 +: 64] = pt; req_key[r*128 +: 128] = key; req_valid[r] = 1'b1;
    endtask

    task automatic set_rand_req(input int r);
        set_req(r, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic do_reset();
        arst_n = 1'b0; req_valid = '0; rsp_ready = '0; err_clr = 1'b0; core_hold = 1'b0;
        #7 arst_n = 1'b1;
        tick();
        rr_last = NREQ - 1;
    endtask

    task automatic wait_accept(output int who, output bit ok);
        who = -1;
        for (int c = 0; c < 40 && req_ready === '0; c++) tick();
        for (int n = 0; n < NREQ; n++) if (req_ready[n] === 1'b1) who = n;
        ok = (who >= 0);
    endtask

    task automatic wait_rsp(output bit ok);
        for (int c = 0; c < 40 && rsp_valid === '0; c++) tick();
        ok = (rsp_valid !== '0);
    endtask

    // full transaction: accept, drop request, optional stall in RESP, consume
    task automatic serve(input int hold, output int who, output logic [63:0] got,
                         output logic [63:0] exp, output bit ok);
        bit a;
        got = '0; exp = '0; ok = 1'b0;
        wait_accept(who, a);
        if (!a) return;
        exp = simon(req_mode[who], req_pt[who*64 +: 64], req_key[who*128 +: 128]);
        tick();
        req_valid[who] = 1'b0;
        wait_rsp(a);
        if (!a || rsp_valid !== onehot(who)) return;
        repeat (hold) tick();
        if (rsp_valid !== onehot(who)) return;
        got = rsp_ct;
        rsp_ready[who] = 1'b1;
        tick();
        rsp_ready[who] = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = '1; rsp_ready = '1; err_clr = 1'b0;
        #1 arst_n = 1'b0;
        #2;
        n_cmp++; if (outs_zero() !== 1'b1) begin n_bad++; $display("FAIL reset_outs: grant=%b busy=%b req_ready=%b core_valid_i=%b, want all zero", grant, busy, req_ready, core_valid_i); end
        req_valid = '0; rsp_ready = '0;
        #4 arst_n = 1'b1;
        tick();
        n_cmp++; if (outs_zero() !== 1'b1) begin n_bad++; $display("FAIL reset_release: grant=%b busy=%b err=%b, want all zero", grant, busy, err_timeout); end
        rr_last = NREQ - 1;
    endtask

    task automatic test_single();
        logic [63:0]  pt  = 64'h0123_4567_89ab_cdef;
        logic [127:0] key = {4{32'hdeadbeef}};
        logic [63:0]  ct, got, exp;
        int who; bit ok;
        core_lat = 2;
        set_req(0, 1'b0, pt, key);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_cycle0_idle: busy=%b want 0", busy); end
        tick();
        n_cmp++; if ({grant, core_valid_i, req_ready} !== {2'b01, 1'b1, 2'b01}) begin n_bad++; $display("FAIL single_cycle1: grant=%b core_valid_i=%b req_ready=%b want 01 1 01", grant, core_valid_i, req_ready); end
        n_cmp++; if ({core_mode_i, core_pt_i, core_key_i} !== {1'b0, pt, key}) begin n_bad++; $display("FAIL single_operands: mode=%b pt=%h key=%h want 0 %h %h", core_mode_i, core_pt_i, core_key_i, pt, key); end
        tick();
        req_valid[0] = 1'b0;
        n_cmp++; if ({req_ready, busy, core_valid_i} !== {2'b00, 1'b1, 1'b0}) begin n_bad++; $display("FAIL single_busy: req_ready=%b busy=%b core_valid_i=%b want 00 1 0", req_ready, busy, core_valid_i); end
        wait_rsp(ok);
        ct = simon(1'b0, pt, key);
        n_cmp++; if ({ok, rsp_valid, rsp_ct, core_ready_i} !== {1'b1, 2'b01, ct, 1'b0}) begin n_bad++; $display("FAIL single_rsp: rsp_valid=%b rsp_ct=%h core_ready_i=%b want 01 %h 0", rsp_valid, rsp_ct, core_ready_i, ct); end
        rsp_ready[0] = 1'b1;
        #1;
        n_cmp++; if (core_ready_i !== 1'b1) begin n_bad++; $display("FAIL single_core_ready_i: got %b want 1", core_ready_i); end
        tick();
        rsp_ready[0] = 1'b0;
        n_cmp++; if ({busy, grant, err_timeout, rsp_valid} !== '0) begin n_bad++; $display("FAIL single_done: busy=%b grant=%b err=%b rsp_valid=%b want 0", busy, grant, err_timeout, rsp_valid); end
        // decrypt of the result must return the original block
        set_req(0, 1'b1, ct, key);
        serve(0, who, got, exp, ok);
        n_cmp++; if ({ok, who, got} !== {1'b1, 0, pt}) begin n_bad++; $display("FAIL single_decrypt: ok=%b who=%0d got %h want %h", ok, who, got, pt); end
        rr_last = 0;
    endtask

    task automatic test_contention();
        int who, ew; bit ok;
        logic [63:0] got, exp;
        do_reset();
        core_lat = 1;
        set_rand_req(0); set_rand_req(1);
        for (int k = 0; k < 6; k++) begin
            ew = ref_winner(req_valid, rr_last);
            tick();
            n_cmp++; if (grant !== onehot(ew)) begin n_bad++; $display("FAIL contend_grant%0d: got %b want %b", k, grant, onehot(ew)); end
            n_cmp++; if (ew != k % 2) begin n_bad++; $display("FAIL contend_order%0d: got %0d want %0d", k, ew, k % 2); end
            serve(0, who, got, exp, ok);
            n_cmp++; if ({ok, who, got} !== {1'b1, ew, exp}) begin n_bad++; $display("FAIL contend_xfer%0d: ok=%b who=%0d ct=%h want 1 %0d %h", k, ok, who, got, ew, exp); end
            n_cmp++; if ({busy, grant} !== '0) begin n_bad++; $display("FAIL contend_idle%0d: busy=%b grant=%b want 0 00", k, busy, grant); end
            rr_last = ew;
            set_rand_req(ew);
        end
        // drain outstanding requests
        for (int k = 0; k < 2; k++) begin
            serve(0, who, got, exp, ok);
            rr_last = who;
        end
    endtask

    task automatic test_backpressure();
        int who; bit ok, held;
        logic [63:0] exp;
        core_lat = 0;
        set_rand_req(0);
        wait_accept(who, ok);
        exp = simon(req_mode[0], req_pt[63:0], req_key[127:0]);
        tick();
        req_valid[0] = 1'b0;
        wait_rsp(ok);
        held = ok;
        rsp_ready[1] = 1'b1;  // non-owner: must be ignored
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_valid !== 2'b01 || core_ready_i !== 1'b0 || busy !== 1'b1) held = 1'b0;
        end
        n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL bp_hold: rsp_valid=%b core_ready_i=%b busy=%b want 01 0 1", rsp_valid, core_ready_i, busy); end
        rsp_ready = 2'b01;
        #1;
        n_cmp++; if ({core_ready_i, rsp_ct} !== {1'b1, exp}) begin n_bad++; $display("FAIL bp_release: core_ready_i=%b ct=%h want 1 %h", core_ready_i, rsp_ct, exp); end
        tick();
        rsp_ready = '0;
        n_cmp++; if ({busy, grant} !== '0) begin n_bad++; $display("FAIL bp_idle: busy=%b grant=%b want 0 00", busy, grant); end
        rr_last = 0;
    endtask

    task automatic test_withdraw();
        int who; bit ok, pulsed;
        logic [63:0] got, exp;
        core_rdy_en = 1'b0;
        set_rand_req(1);
        tick();
        n_cmp++; if ({grant, core_valid_i, req_ready} !== {2'b10, 1'b1, 2'b00}) begin n_bad++; $display("FAIL wd_issue: grant=%b core_valid_i=%b req_ready=%b want 10 1 00", grant, core_valid_i, req_ready); end
        pulsed = 1'b0;
        repeat (2) begin tick(); if (req_ready !== '0) pulsed = 1'b1; end
        req_valid[1] = 1'b0;
        #1;
        if (req_ready !== '0 || core_valid_i !== 1'b0) pulsed = 1'b1;
        tick();
        n_cmp++; if ({pulsed, busy, grant} !== '0) begin n_bad++; $display("FAIL wd_idle: pulsed=%b busy=%b grant=%b want 0 0 00", pulsed, busy, grant); end
        rr_last = 1;
        core_rdy_en = 1'b1;
        set_rand_req(0); set_rand_req(1);
        serve(0, who, got, exp, ok);
        n_cmp++; if ({ok, who, got} !== {1'b1, 0, exp}) begin n_bad++; $display("FAIL wd_next0: ok=%b who=%0d ct=%h want 1 0 %h", ok, who, got, exp); end
        serve(0, who, got, exp, ok);
        n_cmp++; if ({ok, who, got} !== {1'b1, 1, exp}) begin n_bad++; $display("FAIL wd_next1: ok=%b who=%0d ct=%h want 1 1 %h", ok, who, got, exp); end
        rr_last = 1;
    endtask

    task automatic test_timeout();
        int who; bit ok;
        logic [63:0] exp;
        core_lat = 0; core_hold = 1'b1;
        set_rand_req(0);
        wait_accept(who, ok);
        exp = simon(req_mode[0], req_pt[63:0], req_key[127:0]);
        tick();
        req_valid[0] = 1'b0;
        repeat (TIMEOUT - 1) tick();
        n_cmp++; if ({err_timeout, busy} !== 2'b01) begin n_bad++; $display("FAIL to_early: err=%b busy=%b want 0 1", err_timeout, busy); end
        err_clr = 1'b1;  // collides with the set: set must win
        tick();
        n_cmp++; if ({err_timeout, busy} !== 2'b11) begin n_bad++; $display("FAIL to_set: err=%b busy=%b want 1 1", err_timeout, busy); end
        tick();
        err_clr = 1'b0;
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_clr: err=%b want 0", err_timeout); end
        repeat (4) tick();
        n_cmp++; if ({err_timeout, busy, rsp_valid} !== {1'b0, 1'b1, 2'b00}) begin n_bad++; $display("FAIL to_stay: err=%b busy=%b rsp_valid=%b want 0 1 00", err_timeout, busy, rsp_valid); end
        core_hold = 1'b0;
        wait_rsp(ok);
        n_cmp++; if ({ok, rsp_valid, rsp_ct} !== {1'b1, 2'b01, exp}) begin n_bad++; $display("FAIL to_late: rsp_valid=%b ct=%h want 01 %h", rsp_valid, rsp_ct, exp); end
        rsp_ready[0] = 1'b1; tick(); rsp_ready[0] = 1'b0;
        n_cmp++; if ({busy, grant} !== '0) begin n_bad++; $display("FAIL to_idle: busy=%b grant=%b want 0 00", busy, grant); end
        rr_last = 0;
    endtask

    task automatic test_async_reset();
        int who; bit ok;
        logic [63:0] got, exp;
        for (int phase = 0; phase < 2; phase++) begin
            core_lat = 0; core_hold = (phase == 0);
            set_rand_req(0);
            wait_accept(who, ok);
            tick();
            req_valid[0] = 1'b0;
            if (phase == 0) tick(); else wait_rsp(ok);
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ar_pre%0d: busy=%b want 1", phase, busy); end
            #2 arst_n = 1'b0;
            #1;
            n_cmp++; if (outs_zero() !== 1'b1) begin n_bad++; $display("FAIL ar_outs%0d: grant=%b busy=%b rsp_valid=%b core_ready_i=%b want all zero", phase, grant, busy, rsp_valid, core_ready_i); end
            #3 arst_n = 1'b1;
            core_hold = 1'b0;
            tick();
            rr_last = NREQ - 1;
            set_rand_req(1);
            serve(0, who, got, exp, ok);
            n_cmp++; if ({ok, who, got} !== {1'b1, 1, exp}) begin n_bad++; $display("FAIL ar_after%0d: ok=%b who=%0d ct=%h want 1 1 %h", phase, ok, who, got, exp); end
            rr_last = 1;
        end
    endtask

    task automatic test_random();
        int who, ew, bad_w = 0, bad_ct = 0;
        bit ok;
        logic [63:0] got, exp;
        set_rand_req(0);
        if ($urandom_range(0, 1) == 1) set_rand_req(1);
        for (int k = 0; k < 40; k++) begin
            core_lat = $urandom_range(0, 4);
            ew = ref_winner(req_valid, rr_last);
            serve($urandom_range(0, 3), who, got, exp, ok);
            if (!ok || who != ew) bad_w++;
            if (got !== exp) bad_ct++;
            rr_last = who;
            for (int n = 0; n < NREQ; n++)
                if (!req_valid[n] && $urandom_range(0, 1) == 1) set_rand_req(n);
            if (req_valid == '0) set_rand_req($urandom_range(0, NREQ - 1));
        end
        n_cmp++; if (bad_w != 0) begin n_bad++; $display("FAIL rand_winner: %0d wrong owners, want 0", bad_w); end
        n_cmp++; if (bad_ct != 0) begin n_bad++; $display("FAIL rand_ct: %0d wrong results, want 0", bad_ct); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL rand_err: err=%b want 0", err_timeout); end
    endtask

    initial begin
        req_valid = '0; req_mode = '0; req_pt = '0; req_key = '0; rsp_ready = '0; err_clr = 1'b0;
        core_rdy_en = 1'b1; core_hold = 1'b0; core_lat = 1; rr_last = NREQ - 1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_withdraw();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
